timer_tick_sequencer: RTL
=========================

// Module: timer_tick_sequencer
// PURPOSE
//  Avalon-MM master that programs and services the interval timer's s1 slave (regs: 0 status,
//  1 control, 2/3 period_l/h, 4/5 snap_l/h). On start: loads period, starts timer (ITO=1),
//  waits for irq, clears status, emits one tick per timeout. Supports one-shot/continuous,
//  stop, and counter snapshot. Sits between keypad scan logic and timer so no CPU needed.
// PARAMETERS
//  DATA_W   16  timer s1 data width (fixed by timer; do not change)
//  ADDR_W   3   timer s1 address width
//  CNT_W    16  width of tick_count
// PORTS
//  clk            in   1       system clock (same clock as timer)
//  reset          in   1       synchronous, active-high reset
//  start          in   1       pulse: begin sequence; ignored while busy
//  stop           in   1       pulse: stop timer; ignored in IDLE
//  snap_req       in   1       pulse: capture live counter; honoured only in WAIT_IRQ
//  cfg_period     in   32      period, sampled on accepted start; interval = cfg_period+1 clks
//  cfg_continuous in   1       1 = free-running, 0 = one-shot; sampled on accepted start
//  busy           out  1       high in every state except IDLE
//  tick           out  1       1-cycle pulse per serviced timeout
//  done           out  1       1-cycle pulse when one-shot completes or stop finishes
//  tick_count     out  CNT_W   ticks since last accepted start; wraps 2^CNT_W-1 -> 0
//  snap_valid     out  1       1-cycle pulse, snap_value updated
//  snap_value     out  32      last captured counter value
//  tmr_address    out  ADDR_W  to timer s1
//  tmr_chipselect out  1       to timer s1
//  tmr_write_n    out  1       to timer s1, active low
//  tmr_writedata  out  DATA_W  to timer s1
//  tmr_readdata   in   DATA_W  from timer s1; registered, valid 1 clk after address driven
//  tmr_irq        in   1       from timer; = timeout_occurred & ITO
// BEHAVIOUR
//  Reset: state IDLE; busy/tick/done/snap_valid=0; tick_count=0; snap_value=0;
//   tmr_chipselect=0, tmr_write_n=1, tmr_address=0, tmr_writedata=0. All outputs registered.
//  Every write = one cycle, chipselect=1, write_n=0; no waitrequest. Reads: chipselect=0 OK.
//  FSM:
//   IDLE    : start -> latch cfg, clear tick_count, WR_PL
//   WR_PL   : write addr2 = period[15:0]           -> WR_PH
//   WR_PH   : write addr3 = period[31:16]          -> WR_CTRL
//   WR_CTRL : write addr1 = {0,1,cont,1} (START|CONT|ITO) -> WAIT_IRQ
//   WAIT_IRQ: priority stop_pend > tmr_irq > snap_req
//             stop_pend -> WR_STOP; irq -> CLR_STS; snap_req -> SNAP_WR; else stay
//   CLR_STS : write addr0 = 0; pulse tick; tick_count++ ; cont ? WAIT_IRQ : FIN
//   SNAP_WR : write addr4 (any data)               -> SNAP_RDL
//   SNAP_RDL: drive addr4, no cs                  -> SNAP_RDH
//   SNAP_RDH: drive addr5; snap_value[15:0]=rd    -> SNAP_CAP
//   SNAP_CAP: snap_value[31:16]=rd; pulse snap_valid -> WAIT_IRQ
//   WR_STOP : write addr1 = 4'b1000 (STOP, ITO=0)  -> CLR_STS_S
//   CLR_STS_S: write addr0 = 0 (no tick)           -> FIN
//   FIN     : pulse done                           -> IDLE
//  stop in any busy state sets stop_pend; cleared on entry to WR_STOP or FIN. stop same cycle
//   as accepted start: start wins, stop dropped.
//  irq arriving during SNAP_*: stays asserted in timer, serviced on return to WAIT_IRQ.
//  irq already high entering WAIT_IRQ after CLR_STS: impossible (status write clears same edge);
//   if seen, treated as a new timeout.
//  cfg_period=0: legal; timer times out each clock, ticks limited by FSM loop (2 clk/tick).
//  reset mid-sequence: FSM to IDLE, no bus cycle issued; timer state untouched (own reset).
//  tick and done never coincide except one-shot: tick in CLR_STS, done in FIN (next cycle).
// STRUCTURE
//  Package timer_seq_pkg: state enum; reg addr constants (STATUS=0,CONTROL=1,PERL=2,PERH=3,
//   SNAPL=4,SNAPH=5); control bit positions (ITO=0,CONT=1,START=2,STOP=3).
//  Single module; no sub-module. Bench instantiates real timer as DUT partner.
// TESTING
//  One-shot: cfg_period=9, cont=0, start -> one tick ~10 clks after WR_CTRL, done next clk, count=1.
//  Continuous: cfg_period=99, cont=1 -> ticks 100 clks apart; after 5 ticks tick_count=5, busy=1.
//  Stop: during continuous, stop -> writes 0x8 to addr1, 0x0 to addr0, done, IDLE; irq stays 0.
//  Snapshot: period=0xFFFF_FFFF, snap_req 50 clks after start -> snap_value within 0xFFFFFFFF-60..-40.
//  Collisions: start while busy ignored; irq during SNAP_RDH serviced after SNAP_CAP, no lost tick.
//  Wrap/reset: CNT_W=4 run 17 ticks -> tick_count=1; reset in SNAP_RDL -> all outputs reset values.

Source files
------------

// File: rtl/timer_tick_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// timer_seq_pkg
//   Shared definitions for timer_tick_sequencer: the sequencer state
//   encoding, the interval-timer s1 register map and the control-register
//   bit positions, plus a helper that assembles a control word.
// ---------------------------------------------------------------------------
package timer_seq_pkg;

  // Sequencer states, in the order a normal run visits them.
  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_WR_PL     = 4'd1,
    S_WR_PH     = 4'd2,
    S_WR_CTRL   = 4'd3,
    S_WAIT_IRQ  = 4'd4,
    S_CLR_STS   = 4'd5,
    S_SNAP_WR   = 4'd6,
    S_SNAP_RDL  = 4'd7,
    S_SNAP_RDH  = 4'd8,
    S_SNAP_CAP  = 4'd9,
    S_WR_STOP   = 4'd10,
    S_CLR_STS_S = 4'd11,
    S_FIN       = 4'd12
  } seq_state_e;

  // Interval timer s1 register map.
  localparam logic [2:0] REG_STATUS  = 3'd0;
  localparam logic [2:0] REG_CONTROL = 3'd1;
  localparam logic [2:0] REG_PERL    = 3'd2;
  localparam logic [2:0] REG_PERH    = 3'd3;
  localparam logic [2:0] REG_SNAPL   = 3'd4;
  localparam logic [2:0] REG_SNAPH   = 3'd5;

  // Control register bit positions.
  localparam int unsigned CTRL_ITO   = 0;
  localparam int unsigned CTRL_CONT  = 1;
  localparam int unsigned CTRL_START = 2;
  localparam int unsigned CTRL_STOP  = 3;

  // Assemble a 4-bit control word from its individual flags.
  function automatic logic [3:0] ctrl_word(input logic start_b,
                                           input logic cont_b,
                                           input logic stop_b,
                                           input logic ito_b);
    logic [3:0] w;
    w             = 4'b0000;
    w[CTRL_ITO]   = ito_b;
    w[CTRL_CONT]  = cont_b;
    w[CTRL_START] = start_b;
    w[CTRL_STOP]  = stop_b;
    return w;
  endfunction

endpackage

// File: rtl/timer_tick_sequencer.sv
// ---------------------------------------------------------------------------
// timer_tick_sequencer
//   Avalon-MM master that programs and services an interval timer's s1
//   slave without CPU involvement. On an accepted start it loads the
//   period, starts the timer with its interrupt enabled, then converts each
//   timeout interrupt into a one-cycle tick after clearing the status
//   register. Supports one-shot / continuous modes, stop, and a snapshot of
//   the live down-counter.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   start             pulse: begin a sequence (ignored while busy)
//   stop              pulse: stop the timer (ignored in IDLE)
//   snap_req          pulse: capture live counter (honoured only while
//                     waiting for an interrupt)
//   cfg_period        period, sampled on accepted start (interval = +1 clk)
//   cfg_continuous    1 = free-running, 0 = one-shot, sampled on start
//   busy              high whenever not idle
//   tick              one pulse per serviced timeout
//   done              pulse when a one-shot completes or a stop finishes
//   tick_count        ticks since the last accepted start (wrapping)
//   snap_valid        pulse marking a freshly updated snap_value
//   snap_value        last captured counter value
//   tmr_*             Avalon-MM master signals to the timer s1 slave
//   tmr_irq           timer interrupt (timeout & ITO)
//
// All outputs are registered. Bus outputs are decoded from the next state
// so that each bus cycle lines up exactly with the state that owns it.
// ---------------------------------------------------------------------------
module timer_tick_sequencer
  import timer_seq_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              snap_req,
  input  logic [31:0]       cfg_period,
  input  logic              cfg_continuous,
  output logic              busy,
  output logic              tick,
  output logic              done,
  output logic [CNT_W-1:0]  tick_count,
  output logic              snap_valid,
  output logic [31:0]       snap_value,
  output logic [ADDR_W-1:0] tmr_address,
  output logic              tmr_chipselect,
  output logic              tmr_write_n,
  output logic [DATA_W-1:0] tmr_writedata,
  input  logic [DATA_W-1:0] tmr_readdata,
  input  logic              tmr_irq
);

  seq_state_e        state_r;
  seq_state_e        state_s;

  logic              start_acc_s;
  logic [31:0]       period_r;
  logic [31:0]       period_s;
  logic              cont_r;
  logic              stop_pend_r;
  logic [DATA_W-1:0] snap_lo_r;

  logic              busy_r;
  logic              tick_r;
  logic              done_r;
  logic [CNT_W-1:0]  tick_count_r;
  logic              snap_valid_r;
  logic [31:0]       snap_value_r;

  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] addr_s;
  logic              cs_r;
  logic              cs_s;
  logic              wr_n_r;
  logic              wr_n_s;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] wdata_s;

  // A start only counts when the sequencer is idle.
  assign start_acc_s = (state_r == S_IDLE) && start;

  // The period write is issued in the very cycle after the start, before
  // period_r has been loaded, so bypass the freshly sampled value.
  assign period_s = start_acc_s ? cfg_period : period_r;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s = S_WR_PL;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_WR_PL:   state_s = S_WR_PH;
      S_WR_PH:   state_s = S_WR_CTRL;
      S_WR_CTRL: state_s = S_WAIT_IRQ;
      S_WAIT_IRQ: begin
        // Stop outranks a pending timeout; a timeout outranks a snapshot.
        if (stop_pend_r) begin
          state_s = S_WR_STOP;
        end else if (tmr_irq) begin
          state_s = S_CLR_STS;
        end else if (snap_req) begin
          state_s = S_SNAP_WR;
        end else begin
          state_s = S_WAIT_IRQ;
        end
      end
      S_CLR_STS: begin
        if (cont_r) begin
          state_s = S_WAIT_IRQ;
        end else begin
          state_s = S_FIN;
        end
      end
      S_SNAP_WR:   state_s = S_SNAP_RDL;
      S_SNAP_RDL:  state_s = S_SNAP_RDH;
      S_SNAP_RDH:  state_s = S_SNAP_CAP;
      S_SNAP_CAP:  state_s = S_WAIT_IRQ;
      S_WR_STOP:   state_s = S_CLR_STS_S;
      S_CLR_STS_S: state_s = S_FIN;
      S_FIN:       state_s = S_IDLE;
      default:     state_s = S_IDLE;
    endcase
  end

  // Bus cycle owned by the state being entered.
  always_comb begin
    cs_s    = 1'b0;
    wr_n_s  = 1'b1;
    addr_s  = {ADDR_W{1'b0}};
    wdata_s = {DATA_W{1'b0}};
    case (state_s)
      S_WR_PL: begin
        cs_s    = 1'b1;
        wr_n_s  = 1'b0;
        addr_s  = ADDR_W'(REG_PERL);
        wdata_s = DATA_W'(period_s[15:0]);
      end
      S_WR_PH: begin
        cs_s    = 1'b1;
        wr_n_s  = 1'b0;
        addr_s  = ADDR_W'(REG_PERH);
        wdata_s = DATA_W'(period_s[31:16]);
      end
      S_WR_CTRL: begin
        cs_s    = 1'b1;
        wr_n_s  = 1'b0;
        addr_s  = ADDR_W'(REG_CONTROL);
        wdata_s = DATA_W'(ctrl_word(1'b1, cont_r, 1'b0, 1'b1));
      end
      S_CLR_STS, S_CLR_STS_S: begin
        cs_s    = 1'b1;
        wr_n_s  = 1'b0;
        addr_s  = ADDR_W'(REG_STATUS);
        wdata_s = {DATA_W{1'b0}};
      end
      S_SNAP_WR: begin
        // Any write to snap_l latches the live counter.
        cs_s    = 1'b1;
        wr_n_s  = 1'b0;
        addr_s  = ADDR_W'(REG_SNAPL);
        wdata_s = {DATA_W{1'b0}};
      end
      S_SNAP_RDL: begin
        addr_s  = ADDR_W'(REG_SNAPL);
      end
      S_SNAP_RDH: begin
        addr_s  = ADDR_W'(REG_SNAPH);
      end
      S_WR_STOP: begin
        // STOP with ITO cleared so no further interrupt is raised.
        cs_s    = 1'b1;
        wr_n_s  = 1'b0;
        addr_s  = ADDR_W'(REG_CONTROL);
        wdata_s = DATA_W'(ctrl_word(1'b0, 1'b0, 1'b1, 1'b0));
      end
      default: begin
        cs_s    = 1'b0;
        wr_n_s  = 1'b1;
        addr_s  = {ADDR_W{1'b0}};
        wdata_s = {DATA_W{1'b0}};
      end
    endcase
  end

  // Bus output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_r    <= 1'b0;
      wr_n_r  <= 1'b1;
      addr_r  <= {ADDR_W{1'b0}};
      wdata_r <= {DATA_W{1'b0}};
    end else begin
      cs_r    <= cs_s;
      wr_n_r  <= wr_n_s;
      addr_r  <= addr_s;
      wdata_r <= wdata_s;
    end
  end

  // Configuration captured on an accepted start.
  always_ff @(posedge clk) begin
    if (reset) begin
      period_r <= 32'd0;
      cont_r   <= 1'b0;
    end else if (start_acc_s) begin
      period_r <= cfg_period;
      cont_r   <= cfg_continuous;
    end
  end

  // Stop request latch; a stop in IDLE (including one coincident with an
  // accepted start) is dropped, and the latch clears once the stop or
  // completion path is entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      stop_pend_r <= 1'b0;
    end else if ((state_s == S_WR_STOP) || (state_s == S_FIN) ||
                 (state_s == S_IDLE)) begin
      stop_pend_r <= 1'b0;
    end else if (stop && (state_r != S_IDLE)) begin
      stop_pend_r <= 1'b1;
    end
  end

  // Status outputs: busy, tick and done follow the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r <= 1'b0;
      tick_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_s != S_IDLE);
      tick_r <= (state_s == S_CLR_STS);
      done_r <= (state_s == S_FIN);
    end
  end

  // Tick counter, restarted by every accepted start, wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_count_r <= {CNT_W{1'b0}};
    end else if (start_acc_s) begin
      tick_count_r <= {CNT_W{1'b0}};
    end else if (state_s == S_CLR_STS) begin
      tick_count_r <= tick_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Snapshot capture. Readdata lags the address by one clock, so the low
  // half arrives in SNAP_RDH and the high half in SNAP_CAP. The low half
  // is parked so that snap_value changes as a whole, together with
  // snap_valid, in the cycle after SNAP_CAP.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_lo_r    <= {DATA_W{1'b0}};
      snap_value_r <= 32'd0;
      snap_valid_r <= 1'b0;
    end else begin
      snap_valid_r <= (state_r == S_SNAP_CAP);
      if (state_r == S_SNAP_RDH) begin
        snap_lo_r <= tmr_readdata;
      end
      if (state_r == S_SNAP_CAP) begin
        snap_value_r <= {tmr_readdata, snap_lo_r};
      end
    end
  end

  assign busy           = busy_r;
  assign tick           = tick_r;
  assign done           = done_r;
  assign tick_count     = tick_count_r;
  assign snap_valid     = snap_valid_r;
  assign snap_value     = snap_value_r;
  assign tmr_address    = addr_r;
  assign tmr_chipselect = cs_r;
  assign tmr_write_n    = wr_n_r;
  assign tmr_writedata  = wdata_r;

endmodule
